// File: rtl/sd_spi_host.sv
// SD-card SPI-mode host: SCLK divider, power-up dummy clocks, 48-bit command shifter and R1/R3/R7 receiver.
// Optional: define SD_CRC7_AUTO_EN to replace the frame's CRC byte with a computed CRC7 and end bit.
`timescale 1ns/1ps
module sd_spi_host #(
    parameter int SLOW_HALF = 63,
    parameter int FAST_HALF = 1,
    parameter int INIT_CLKS = 80,
    parameter int NCR_MAX   = 64
) (
    input  logic        clk,
    input  logic        res,
    input  logic        speed,
    output logic        sd_clk,
    input  logic [47:0] spi_cmd_data,
    input  logic        spi_cmd,
    output logic        spi_busy,
    output logic        spi_error,
    output logic [47:0] spi_response,
    output logic        card_MOSI,
    input  logic        card_MISO,
    output logic        card_CS
);

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_SEND, ST_WAIT, ST_RECV, ST_TAIL} state_t;

    state_t      r_state, w_next;
    logic [6:0]  r_half, r_div_cnt;
    logic        r_sclk, r_cs, r_mosi, r_busy, r_error;
    logic [47:0] r_resp, r_tx, r_rx;
    logic [7:0]  r_bitcnt;
    logic [5:0]  r_idx;
    logic        w_tc, w_rise, w_fall, w_long, w_last_bit;
    logic        w_accept, w_timeout, w_resp_done;
    logic [47:0] w_frame, w_rx_next;

`ifdef SD_CRC7_AUTO_EN
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction
    assign w_frame = {spi_cmd_data[47:8], crc7(spi_cmd_data[47:8]), 1'b1};
`else
    assign w_frame = spi_cmd_data;
`endif

    // Divider is frozen in IDLE so sd_clk can only change speed while parked low.
    assign w_tc       = (r_state != ST_IDLE) && (r_div_cnt == r_half - 7'd1);
    assign w_rise     = w_tc & ~r_sclk;
    assign w_fall     = w_tc & r_sclk;
    assign w_long     = (r_idx == 6'd8) || (r_idx == 6'd58);
    assign w_last_bit = r_bitcnt == (w_long ? 8'd39 : 8'd7);
    assign w_rx_next  = {r_rx[46:0], card_MISO};

    always_ff @(posedge clk) begin
        if (res) r_state <= ST_INIT;
        else     r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next      = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_resp_done = 1'b0;
        unique case (r_state)
            ST_INIT: if (w_fall && r_bitcnt == 8'(INIT_CLKS)) w_next = ST_IDLE;
            ST_IDLE: if (spi_cmd) begin
                w_accept = 1'b1;
                w_next   = ST_SEND;
            end
            ST_SEND: if (w_fall && r_bitcnt == 8'd48) w_next = ST_WAIT;
            ST_WAIT: if (w_rise) begin
                if (card_MISO == 1'b0) begin
                    w_next = ST_RECV;
                end else if (r_bitcnt == 8'(NCR_MAX - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = ST_TAIL;
                end
            end
            ST_RECV: if (w_rise && w_last_bit) begin
                w_resp_done = 1'b1;
                w_next      = ST_TAIL;
            end
            ST_TAIL: if (w_fall && r_bitcnt == 8'd8) w_next = ST_IDLE;
            default: w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_sclk    <= 1'b0;
            r_div_cnt <= '0;
            r_half    <= 7'(SLOW_HALF);
            r_cs      <= 1'b1;
            r_mosi    <= 1'b1;
            r_busy    <= 1'b1;
            r_error   <= 1'b0;
            r_resp    <= '0;
            r_bitcnt  <= '0;
            r_tx      <= '1;
            r_rx      <= '0;
            r_idx     <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_div_cnt <= '0;
                r_sclk    <= 1'b0;
            end else if (w_tc) begin
                r_div_cnt <= '0;
                r_sclk    <= ~r_sclk;
            end else begin
                r_div_cnt <= r_div_cnt + 7'd1;
            end

            unique case (r_state)
                ST_INIT: begin
                    if (w_rise) r_bitcnt <= r_bitcnt + 8'd1;
                    if (w_next == ST_IDLE) begin
                        r_busy   <= 1'b0;
                        r_bitcnt <= '0;
                    end
                end
                ST_IDLE: if (w_accept) begin
                    r_mosi   <= w_frame[47];
                    r_tx     <= {w_frame[46:0], 1'b1};
                    r_cs     <= 1'b0;
                    r_busy   <= 1'b1;
                    r_idx    <= spi_cmd_data[45:40];
                    r_half   <= speed ? 7'(FAST_HALF) : 7'(SLOW_HALF);
                    r_bitcnt <= '0;
                    r_rx     <= '0;
                end
                ST_SEND: begin
                    if (w_rise) r_bitcnt <= r_bitcnt + 8'd1;
                    // Ones shifted in behind the frame leave MOSI high once all 48 bits are out.
                    if (w_fall) begin
                        r_mosi <= r_tx[47];
                        r_tx   <= {r_tx[46:0], 1'b1};
                        if (w_next == ST_WAIT) r_bitcnt <= '0;
                    end
                end
                ST_WAIT: if (w_rise) begin
                    if (w_next == ST_RECV) begin
                        r_rx     <= w_rx_next;
                        r_bitcnt <= 8'd1;
                    end else if (w_timeout) begin
                        r_error  <= 1'b1;
                        r_resp   <= '1;
                        r_cs     <= 1'b1;
                        r_mosi   <= 1'b1;
                        r_bitcnt <= '0;
                    end else begin
                        r_bitcnt <= r_bitcnt + 8'd1;
                    end
                end
                ST_RECV: if (w_rise) begin
                    r_rx     <= w_rx_next;
                    r_bitcnt <= r_bitcnt + 8'd1;
                    if (w_resp_done) begin
                        r_resp   <= w_rx_next;
                        r_error  <= w_long ? |w_rx_next[38:33] : |w_rx_next[6:1];
                        r_cs     <= 1'b1;
                        r_mosi   <= 1'b1;
                        r_bitcnt <= '0;
                    end
                end
                ST_TAIL: begin
                    if (w_rise) r_bitcnt <= r_bitcnt + 8'd1;
                    if (w_next == ST_IDLE) begin
                        r_busy   <= 1'b0;
                        r_bitcnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sd_clk       = r_sclk;
    assign card_CS      = r_cs;
    assign card_MOSI    = r_mosi;
    assign spi_busy     = r_busy;
    assign spi_error    = r_error;
    assign spi_response = r_resp;

endmodule

// File: tb/tb_sd_spi_host.sv
// Directed bench for sd_spi_host: card model on the pins, queue scoreboard of expected transaction results.
`timescale 1ns/1ps
module tb_sd_spi_host;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        speed = 1'b0;
    logic        spi_cmd = 1'b0;
    logic [47:0] spi_cmd_data = '0;
    logic        card_MISO = 1'b1;
    logic        sd_clk, spi_busy, spi_error, card_MOSI, card_CS;
    logic [47:0] spi_response;

    sd_spi_host dut (
        .clk          (clk),
        .res          (res),
        .speed        (speed),
        .sd_clk       (sd_clk),
        .spi_cmd_data (spi_cmd_data),
        .spi_cmd      (spi_cmd),
        .spi_busy     (spi_busy),
        .spi_error    (spi_error),
        .spi_response (spi_response),
        .card_MOSI    (card_MOSI),
        .card_MISO    (card_MISO),
        .card_CS      (card_CS)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] resp;
        logic        err;
        logic [47:0] mosi;
        int          rises;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    // Card model: mode 0 holds MISO at miso_level, mode 1 answers after card_ncr filler bits.
    logic        card_mode  = 1'b0;
    logic        miso_level = 1'b1;
    logic [47:0] card_resp  = '0;
    int          card_len   = 8;
    int          card_ncr   = 1;
    logic        prev_sclk  = 1'b0;
    logic        prev_cs    = 1'b1;
    int          rise_cnt   = 0;
    int          rises_total = 0;
    int          k_bit;
    logic [47:0] mosi_cap   = '0;
    longint      t_prev = 0, t_last = 0;

    always @(negedge clk) begin
        if (sd_clk && !prev_sclk) begin
            rises_total++;
            t_prev = t_last;
            t_last = $time;
            if (!prev_cs) begin
                rise_cnt++;
                if (rise_cnt <= 48) mosi_cap = {mosi_cap[46:0], card_MOSI};
            end
        end
        if (!card_CS && prev_cs) rise_cnt = 0;
        k_bit = rise_cnt + 1 - 49 - card_ncr;
        if (card_mode && !card_CS)
            card_MISO = (k_bit >= 0 && k_bit < card_len) ? card_resp[card_len - 1 - k_bit] : 1'b1;
        else
            card_MISO = miso_level;
        prev_sclk = sd_clk;
        prev_cs   = card_CS;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (spi_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle_reached"}, 48'(n < budget), 48'd1);
    endtask

    task automatic run_cmd(input string tag, input logic [47:0] frame, input logic [47:0] resp,
                           input logic err, input logic [47:0] mosi, input int rises);
        exp_t e;
        int   n = 0;
        e.resp = resp; e.err = err; e.mosi = mosi; e.rises = rises;
        exp_q.push_back(e);
        @(negedge clk);
        spi_cmd_data = frame;
        spi_cmd      = 1'b1;
        @(negedge clk);
        spi_cmd = 1'b0;
        check({tag, " busy_cs_after_accept"}, 48'({spi_busy, card_CS}), 48'b10);
        while (card_CS !== 1'b1 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " tail_cs_busy_mosi"}, 48'({card_CS, spi_busy, card_MOSI}), 48'b111);
        wait_idle(tag, 40000);
        e = exp_q.pop_front();
        check({tag, " response"}, spi_response, e.resp);
        check({tag, " error"}, 48'(spi_error), 48'(e.err));
        check({tag, " mosi_frame"}, mosi_cap, e.mosi);
        check({tag, " rises_before_tail"}, 48'(rise_cnt), 48'(e.rises));
    endtask

    initial begin
        int r0;
        int n;
        logic [47:0] crc_mosi;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset pins", 48'({sd_clk, card_CS, card_MOSI, spi_busy, spi_error}), 48'b01110);
        check("reset response", spi_response, 48'h0);
        res = 1'b0;
        r0  = rises_total;

        // Power-up dummy clocks at the slow rate
        n = 0;
        while (rises_total - r0 < 40 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("init mid cs_mosi_busy", 48'({card_CS, card_MOSI, spi_busy}), 48'b111);
        wait_idle("init", 20000);
        check("init rises", 48'(rises_total - r0), 48'd80);
        check("init sclk period", 48'((t_last - t_prev) / 10), 48'd126);
        check("idle sclk parked", 48'(sd_clk), 48'd0);

        // CMD0 with MISO held low: immediate all-zero R1
        card_mode  = 1'b0;
        miso_level = 1'b0;
        run_cmd("cmd0_miso0", 48'h40_0000_0000_95, 48'h0, 1'b0, 48'h40_0000_0000_95, 56);

        // CMD0 with MISO held high: response timeout
        miso_level = 1'b1;
        run_cmd("cmd0_timeout", 48'h40_0000_0000_95, '1, 1'b1, 48'h40_0000_0000_95, 112);

        // Fast clock, CMD8 with a 40-bit R7 answer
        speed     = 1'b1;
        card_mode = 1'b1;
        card_resp = 48'h00_01_0000_01AA;
        card_len  = 40;
        card_ncr  = 1;
        run_cmd("cmd8_fast", 48'h48_0000_01AA_87, 48'h00_01_0000_01AA, 1'b0, 48'h48_0000_01AA_87, 89);
        check("fast sclk period", 48'((t_last - t_prev) / 10), 48'd2);

        // CMD55 returning R1=0x05 (illegal-command bit set)
        card_resp = 48'h05;
        card_len  = 8;
        card_ncr  = 2;
        run_cmd("cmd55_r1err", 48'h77_0000_0000_65, 48'h05, 1'b1, 48'h77_0000_0000_65, 58);

        // Supplied CRC byte zero: replaced by CRC7 only when the option is built in
`ifdef SD_CRC7_AUTO_EN
        crc_mosi = 48'h48_0000_01AA_87;
`else
        crc_mosi = 48'h48_0000_01AA_00;
`endif
        card_resp = 48'h00_01_0000_01AA;
        card_len  = 40;
        card_ncr  = 0;
        run_cmd("cmd8_crc", 48'h48_0000_01AA_00, 48'h00_01_0000_01AA, 1'b0, crc_mosi, 88);

        // Reset in the middle of SEND restarts the power-up sequence
        speed = 1'b0;
        @(negedge clk);
        spi_cmd_data = 48'h40_0000_0000_95;
        spi_cmd      = 1'b1;
        @(negedge clk);
        spi_cmd = 1'b0;
        n = 0;
        while (rise_cnt < 20 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("midsend cs_busy", 48'({card_CS, spi_busy}), 48'b01);
        res = 1'b1;
        repeat (2) @(negedge clk);
        check("midsend reset pins", 48'({sd_clk, card_CS, card_MOSI, spi_busy, spi_error}), 48'b01110);
        check("midsend reset response", spi_response, 48'h0);
        res = 1'b0;
        r0  = rises_total;
        wait_idle("reinit", 20000);
        check("reinit rises", 48'(rises_total - r0), 48'd80);
        check("reinit sclk period", 48'((t_last - t_prev) / 10), 48'd126);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
